// File: rtl/sha_ctrl_pkg.sv
// sha_ctrl_pkg
// Shared control definitions for the SHA-256 datapath sequencing blocks.
//   wen_state_t : run-enable FSM state encoding
//   SHA_ROUNDS  : compression rounds per block, default run length
package sha_ctrl_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } wen_state_t;

    localparam int SHA_ROUNDS = 64;

endpackage

// File: rtl/wen_join_if.sv
// wen_join_if
// Handshake bundle between a start-request source and the wen_join block.
//   start  : per-channel start requests (source -> join)
//   abort  : synchronous cancel (source -> join)
//   enable : registered run enable (join -> round core)
//   busy   : high while a run is active
//   round  : index of the current enable cycle
//   done   : one-cycle end-of-run pulse
//   armed  : latched start flags
interface wen_join_if #(
    parameter int NUM_START = 2,
    parameter int CNT_W     = 7
);
    logic [NUM_START-1:0] start;
    logic                 abort;
    logic                 enable;
    logic                 busy;
    logic [CNT_W-1:0]     round;
    logic                 done;
    logic [NUM_START-1:0] armed;

    modport master (
        output start, abort,
        input  enable, busy, round, done, armed
    );

    modport slave (
        input  start, abort,
        output enable, busy, round, done, armed
    );
endinterface

// File: rtl/start_latch.sv
// start_latch
// One sticky start flag. Sets on start, clears on join or abort; clear wins.
// With STICKY=0 nothing is stored and the raw start passes straight to the
// join term (same-cycle join).
//   clock, reset : clock and async active-high reset
//   set          : start request for this channel
//   clr          : join accepted or abort this cycle
//   flag         : latched state (always 0 when STICKY=0)
//   term         : this channel's contribution to the join AND
module start_latch #(
    parameter bit STICKY = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic set,
    input  logic clr,
    output logic flag,
    output logic term
);
    generate
        if (STICKY) begin : g_sticky
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    flag <= 1'b0;
                end else if (clr) begin
                    flag <= 1'b0;
                end else if (set) begin
                    flag <= 1'b1;
                end
            end
            assign term = flag | set;
        end else begin : g_bypass
            logic unused_bypass;
            assign unused_bypass = &{1'b0, clock, reset, clr};
            assign flag = 1'b0;
            assign term = set;
        end
    endgenerate
endmodule

// File: rtl/wen_join.sv
// wen_join
// Start-join enable generator for the SHA-256 message scheduler and round
// core. Collects NUM_START start requests (sticky or same-cycle), then holds
// a registered enable for RUN_CYCLES cycles and pulses done after the last
// one. A join seen in the final cycle chains the next run without a gap.
//   clock, reset : clock and async active-high reset
//   bus (slave)  : start/abort in; enable/busy/round/done/armed out
//
// state | meaning
// IDLE  | waiting for all start channels to join
// RUN   | enable high, round counting 0..RUN_CYCLES-1
module wen_join
    import sha_ctrl_pkg::*;
#(
    parameter int NUM_START  = 2,
    parameter int RUN_CYCLES = SHA_ROUNDS,
    parameter int CNT_W      = 7,
    parameter bit STICKY     = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    wen_join_if.slave  bus
);
    generate
        if (NUM_START < 1 || RUN_CYCLES < 1 || RUN_CYCLES > (1 << CNT_W)) begin : g_cfg_bad
            $fatal(1, "wen_join: bad NUM_START/RUN_CYCLES/CNT_W combination");
        end
    endgenerate

    localparam logic [CNT_W-1:0] LAST_ROUND = CNT_W'(RUN_CYCLES - 1);

    wen_state_t           state_q, state_d;
    logic [CNT_W-1:0]     round_q, round_d;
    logic                 done_q, done_d;
    logic                 enable_q, busy_q;
    logic                 accept;
    logic                 clr;
    logic                 join_w;
    logic [NUM_START-1:0] term;

    // Starts arriving in the accepting cycle are consumed by that join.
    assign clr = bus.abort | accept;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_START; gi++) begin : g_latch
            start_latch #(.STICKY(STICKY)) u_latch (
                .clock (clock),
                .reset (reset),
                .set   (bus.start[gi]),
                .clr   (clr),
                .flag  (bus.armed[gi]),
                .term  (term[gi])
            );
        end
    endgenerate

    assign join_w = &term;

    always_comb begin
        state_d = state_q;
        round_d = round_q;
        done_d  = 1'b0;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                round_d = '0;
                if (!bus.abort && join_w) begin
                    state_d = RUN;
                    accept  = 1'b1;
                end
            end
            RUN: begin
                if (bus.abort) begin
                    state_d = IDLE;
                    round_d = '0;
                end else if (round_q == LAST_ROUND) begin
                    done_d  = 1'b1;
                    round_d = '0;
                    if (join_w) begin
                        accept = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    round_d = round_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                round_d = '0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            round_q  <= '0;
            done_q   <= 1'b0;
            enable_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            round_q  <= round_d;
            done_q   <= done_d;
            enable_q <= (state_d == RUN);
            busy_q   <= (state_d == RUN);
        end
    end

    assign bus.enable = enable_q;
    assign bus.busy   = busy_q;
    assign bus.round  = round_q;
    assign bus.done   = done_q;
endmodule

// File: doc/wen_join.md
# wen_join

Parametrised start-join enable generator for the SHA-256 datapath. It collects NUM_START independent start requests, which may arrive in different cycles. It then asserts a registered `enable` for exactly RUN_CYCLES consecutive cycles (one compression run) and pulses `done` at the end. It replaces the two-input, same-cycle AND enable in front of the message scheduler and round core, and adds sticky capture, round counting, abort and back-to-back chaining.

## Interface
- NUM_START, default 2: number of start channels, ≥1.
- RUN_CYCLES, default 64: cycles `enable` is held per run, 1..2^CNT_W.
- CNT_W, default 7: width of the round counter.
- STICKY, default 1: 1 = starts latched until join; 0 = all starts must be high in the same cycle (legacy join).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset; one clock domain only.
- start  in  NUM_START  per-channel start requests, level or pulse.
- abort  in  1  synchronous cancel of the pending or running job.
- enable  out  1  registered run enable to the round core.
- busy  out  1  high while in RUN.
- round  out  CNT_W  index of the current enable cycle, 0..RUN_CYCLES-1; 0 when idle.
- done  out  1  one-cycle pulse after the final enable cycle of a run.
- armed  out  NUM_START  latched start flags; all zero when STICKY=0.

## Operation
- States: IDLE and RUN.
- Reset (async): state=IDLE; armed=0; enable=0; busy=0; round=0; done=0.
- Join term: `join = &(armed | start)` when STICKY=1, and `join = &start` when STICKY=0.
- IDLE, STICKY=1: each cycle, armed |= start.
- IDLE with join=1: next state is RUN, enable=1, busy=1, round=0, armed cleared.
- RUN, ordinary cycle: round increments by 1 each cycle, and starts keep accumulating into armed to queue the next job.
- RUN, last cycle (round==RUN_CYCLES-1):
  - Next cycle done=1.
  - If join=1 in that cycle: stay in RUN (chained run), round=0, enable stays 1, armed cleared.
  - Otherwise: go to IDLE, enable=0, busy=0, round=0.
- abort (any state): next cycle IDLE, armed=0, enable=0, busy=0, round=0, done=0. Abort has priority over start and join in the same cycle; the starts from that cycle are dropped.
- RUN_CYCLES=1: every run is one enable cycle, and done follows every run.
- Round counter arithmetic: unsigned, CNT_W bits, never wraps. It is reloaded to 0 at terminal count.
- Elaboration check: RUN_CYCLES ≤ 2^CNT_W, otherwise a fatal assertion fires.

## Timing
- All outputs are registered; there is no combinational path from input to output.
- Join seen in cycle T: enable is 1 in T+1..T+RUN_CYCLES, and round equals k in cycle T+1+k.
- done is 1 in cycle T+RUN_CYCLES+1 only. It is never asserted while enable is newly rising from IDLE.
- Chained run: enable has no gap, and done coincides with round=0 of the next run.
- STICKY=0, RUN_CYCLES=1: `enable` behaves as `start` ANDed over all channels, delayed one cycle. This matches the legacy join.
- Reset asserted mid-run: outputs go to 0 immediately and asynchronously, with no done pulse.
- After reset deassertion, the first join is accepted on the first clock edge.

## Structure
- Shared package `sha_ctrl_pkg` holds:
  - state enum `wen_state_t` {IDLE, RUN};
  - the default constant `SHA_ROUNDS = 64`, used by the instantiator.
- Sub-module `start_latch`: a per-channel sticky flag with set (start), clear (join or abort) and bypass (STICKY=0).
- `wen_join` instantiates NUM_START copies of `start_latch` and holds the FSM and round counter.

## Test plan
- Staggered starts: NUM_START=2, start[0] pulsed at cycle 3, start[1] pulsed at cycle 7.
  - Expected: armed=01 from cycle 4; enable=1 for cycles 8..71; round increments 0..63; done=1 at cycle 72 only.
- Legacy mode: STICKY=0, RUN_CYCLES=1, start pattern 11,10,11.
  - Expected: enable is 1,0,1 one cycle later; done follows each enable by one cycle.
- Chaining: NUM_START=3, all starts re-asserted during round 40 of a run.
  - Expected: armed=111; enable stays high across the boundary; done=1 with round=0; a second run of 64 cycles follows.
- Abort collision: abort and the completing start in the same cycle while in IDLE with armed=01.
  - Expected: next cycle armed=00, enable=0, and no run starts.
  - Also: abort at round 10 gives enable=0 the next cycle and no done.
- Async reset: assert reset at round 20, between clock edges.
  - Expected: enable, busy, round and armed are 0 before the next edge.
  - Expected: a join immediately after release starts a clean run from round=0.
